// File: rtl/string_writer_if.sv
// Command, strings-ROM and text-RAM signals of the string writer.
interface string_writer_if;
    logic        start;
    logic [10:0] str_addr;
    logic [4:0]  dst_row;
    logic [6:0]  dst_col;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        txt_we;
    logic [11:0] txt_addr;
    logic [7:0]  txt_data;
    logic        busy;
    logic        done;
    logic [6:0]  len;

    // Requester plus ROM side: issues commands and returns ROM characters.
    modport master (
        output start, str_addr, dst_row, dst_col, rom_data,
        input  rom_addr, txt_we, txt_addr, txt_data, busy, done, len
    );

    // String writer side.
    modport slave (
        input  start, str_addr, dst_row, dst_col, rom_data,
        output rom_addr, txt_we, txt_addr, txt_data, busy, done, len
    );
endinterface

// File: rtl/string_writer.sv
// Copies a zero-terminated string from the strings ROM into the text RAM
// at a given row/column, one character per cycle, wrapping columns and rows.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; len holds result of the last copy
// RUN   | reading ROM[ptr] each cycle and writing it until 0, MAX_LEN or
//       | the end of the ROM address space
module string_writer #(
    parameter int COLS    = 80,
    parameter int ROWS    = 30,
    parameter int MAX_LEN = 64
) (
    input logic             clk,
    input logic             reset,
    string_writer_if.slave  bus
);
    localparam logic [7:0] COLS_W  = 8'(COLS);
    localparam logic [5:0] ROWS_W  = 6'(ROWS);
    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [6:0] CNT_MAX = 7'(MAX_LEN);
    localparam logic [11:0] COLS_12 = 12'(COLS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [10:0] ptr_q, ptr_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  len_q, len_d;
    logic        end_q, end_d;     // last ROM address already consumed
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic [11:0] lin_addr;

    assign lin_addr = 12'(row_q) * COLS_12 + 12'(col_q);

    // Register all state; reset returns to IDLE with cleared outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            end_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            end_q   <= end_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output decisions for the copy sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        end_d   = end_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ptr_d   = bus.str_addr;
                    row_d   = ({1'b0, bus.dst_row} >= ROWS_W) ? 5'd0 : bus.dst_row;
                    col_d   = ({1'b0, bus.dst_col} >= COLS_W) ? 7'd0 : bus.dst_col;
                    cnt_d   = '0;
                    end_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (end_q || bus.rom_data == 8'd0 || cnt_q >= CNT_MAX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    len_d   = cnt_q;
                end else begin
                    we_d   = 1'b1;
                    data_d = bus.rom_data;
                    addr_d = lin_addr;
                    cnt_d  = cnt_q + 7'd1;
                    // Stop at the top of the ROM instead of wrapping to 0.
                    if (ptr_q == 11'h7FF) begin
                        end_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 11'd1;
                    end
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_addr = ptr_q;
    assign bus.txt_we   = we_q;
    assign bus.txt_addr = addr_q;
    assign bus.txt_data = data_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.len      = len_q;
endmodule

// File: tb/tb_string_writer.sv
// Self-checking bench for string_writer: directed cases plus random copies
// compared against a queue-based model of the expected text RAM writes.
module tb_string_writer;
    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int MAX_LEN = 64;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [7:0] rom [0:2047];
    int   exp_addr[$];
    int   exp_data[$];

    string_writer_if sif ();

    string_writer #(.COLS(COLS), .ROWS(ROWS), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    assign sif.rom_data = rom[sif.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected writes: characters from a upward until 0, MAX_LEN or the ROM
    // end, placed at consecutive linear screen positions modulo the screen.
    task automatic model(input int a, input int r, input int c);
        int rr, cc, p;
        exp_addr.delete();
        exp_data.delete();
        rr = (r >= ROWS) ? 0 : r;
        cc = (c >= COLS) ? 0 : c;
        p  = rr * COLS + cc;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (a + i > 2047) break;
            if (rom[a + i] == 8'd0) break;
            exp_addr.push_back((p + i) % (ROWS * COLS));
            exp_data.push_back(int'(rom[a + i]));
        end
    endtask

    task automatic run_copy(input int a, input int r, input int c, input int mid,
                            input bit started, input bit chain,
                            input int na, input int nr, input int nc);
        int n;
        if (!started) begin
            @(negedge clk);
            sif.start    = 1'b1;
            sif.str_addr = 11'(a);
            sif.dst_row  = 5'(r);
            sif.dst_col  = 7'(c);
        end
        model(a, r, c);
        n = exp_addr.size();
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        check($sformatf("k0_busy a=%0d", a), int'(sif.busy), 1);
        check($sformatf("k0_we a=%0d", a), int'(sif.txt_we), 0);
        check($sformatf("k0_romaddr a=%0d", a), int'(sif.rom_addr), a);
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            sif.start = 1'b0;
            if (k == mid) begin
                sif.start    = 1'b1;
                sif.str_addr = 11'd15;
            end
            if (k <= n) begin
                check($sformatf("we a=%0d k=%0d", a, k), int'(sif.txt_we), 1);
                check($sformatf("addr a=%0d k=%0d", a, k), int'(sif.txt_addr), exp_addr[k-1]);
                check($sformatf("data a=%0d k=%0d", a, k), int'(sif.txt_data), exp_data[k-1]);
                check($sformatf("busy a=%0d k=%0d", a, k), int'(sif.busy), 1);
                check($sformatf("done_early a=%0d k=%0d", a, k), int'(sif.done), 0);
            end else begin
                check($sformatf("end_we a=%0d", a), int'(sif.txt_we), 0);
                check($sformatf("end_done a=%0d", a), int'(sif.done), 1);
                check($sformatf("end_busy a=%0d", a), int'(sif.busy), 0);
                check($sformatf("end_len a=%0d", a), int'(sif.len), n);
                if (chain) begin
                    sif.start    = 1'b1;
                    sif.str_addr = 11'(na);
                    sif.dst_row  = 5'(nr);
                    sif.dst_col  = 7'(nc);
                end
            end
        end
        if (!chain) begin
            @(negedge clk);
            check($sformatf("post_done a=%0d", a), int'(sif.done), 0);
            check($sformatf("post_we a=%0d", a), int'(sif.txt_we), 0);
            check($sformatf("post_len a=%0d", a), int'(sif.len), n);
        end
    endtask

    initial begin
        string s;
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        sif.start    = 1'b0;
        sif.str_addr = '0;
        sif.dst_row  = '0;
        sif.dst_col  = '0;

        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        s = "Ch1 Vdiv:";
        rom[14] = 8'd0;
        for (int i = 0; i < 9; i++) rom[15 + i] = s[i];
        rom[24] = 8'd0;
        for (int i = 100; i < 200; i++) rom[i] = 8'($urandom_range(1, 255));
        s = "ABCD";
        for (int i = 0; i < 4; i++) rom[300 + i] = s[i];
        rom[304] = 8'd0;
        for (int i = 2040; i < 2048; i++) rom[i] = 8'($urandom_range(1, 255));

        // Reset wins over start.
        @(negedge clk);
        sif.start    = 1'b1;
        sif.str_addr = 11'd15;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", int'(sif.busy), 0);
        check("rst_done", int'(sif.done), 0);
        check("rst_we", int'(sif.txt_we), 0);
        check("rst_txt_addr", int'(sif.txt_addr), 0);
        check("rst_txt_data", int'(sif.txt_data), 0);
        check("rst_rom_addr", int'(sif.rom_addr), 0);
        check("rst_len", int'(sif.len), 0);
        sif.start = 1'b0;
        reset     = 1'b0;

        // Reference string, then empty string started in the done cycle.
        run_copy(15, 2, 5, -1, 1'b0, 1'b1, 14, 0, 0);
        run_copy(14, 0, 0, -1, 1'b1, 1'b0, 0, 0, 0);
        // Screen wrap at the bottom-right corner.
        run_copy(300, 29, 78, -1, 1'b0, 1'b0, 0, 0, 0);
        // Length limit with a start attempt while busy.
        run_copy(100, 1, 1, 10, 1'b0, 1'b0, 0, 0, 0);
        // Out-of-range destination replaced by row 0, col 0.
        run_copy(300, 31, 100, -1, 1'b0, 1'b0, 0, 0, 0);
        // Copy stops at the top of the ROM.
        run_copy(2044, 3, 3, -1, 1'b0, 1'b0, 0, 0, 0);

        // Abort a copy with reset after its third write.
        @(negedge clk);
        sif.start    = 1'b1;
        sif.str_addr = 11'd15;
        sif.dst_row  = 5'd2;
        sif.dst_col  = 7'd5;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_3rd_we", int'(sif.txt_we), 1);
        check("abort_3rd_data", int'(sif.txt_data), int'(rom[17]));
        reset = 1'b1;
        @(negedge clk);
        check("abort_we", int'(sif.txt_we), 0);
        check("abort_busy", int'(sif.busy), 0);
        check("abort_done", int'(sif.done), 0);
        check("abort_len", int'(sif.len), 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_we %0d", i), int'(sif.txt_we), 0);
            check($sformatf("abort_quiet_busy %0d", i), int'(sif.busy), 0);
        end
        run_copy(15, 2, 5, -1, 1'b0, 1'b0, 0, 0, 0);

        // Random copies, including out-of-range destinations.
        for (int t = 0; t < 12; t++) begin
            run_copy(int'($urandom_range(0, 2047)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 127)), -1, 1'b0, 1'b0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/string_writer.md
STRING_WRITER -- requirements
Module: string_writer

Interface
REQ-001 The block SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 The block SHALL have parameter ROWS, default 30, meaning text rows.
REQ-003 The block SHALL have parameter MAX_LEN, default 64, meaning the maximum number of characters written per string.
REQ-004 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 Port start  in  1  requests a string copy.
REQ-007 Port str_addr  in  11  is the string start address in the strings ROM.
REQ-008 Port dst_row  in  5  is the destination text row.
REQ-009 Port dst_col  in  7  is the destination text column.
REQ-010 Port rom_addr  out  11  is the strings ROM address.
REQ-011 Port rom_data  in  8  is the ROM character, valid combinationally in the same cycle as rom_addr.
REQ-012 Port txt_we  out  1  is the text RAM write strobe.
REQ-013 Port txt_addr  out  12  is the text RAM address, equal to row*COLS+col.
REQ-014 Port txt_data  out  8  is the character written.
REQ-015 Port busy  out  1  indicates a copy in progress.
REQ-016 Port done  out  1  is a one-cycle completion pulse.
REQ-017 Port len  out  7  is the number of characters written by the last copy.

Function
REQ-018 The block SHALL implement the states IDLE and RUN.
REQ-019 In IDLE, start=1 at edge T SHALL latch ptr=str_addr, row=dst_row, col=dst_col, cnt=0, enter RUN, and set busy=1 from T+1.
REQ-020 A latched dst_col>=COLS SHALL be replaced by 0, and a latched dst_row>=ROWS SHALL be replaced by 0.
REQ-021 rom_addr SHALL equal ptr in all states.
REQ-022 In RUN, when rom_data!=0 and cnt<MAX_LEN, the next edge SHALL register txt_we=1, txt_data=rom_data and txt_addr=row*COLS+col, and SHALL increment ptr, col and cnt.
REQ-023 As a result of REQ-022, one character SHALL be written per cycle, with the first write visible two cycles after the start edge.
REQ-024 Column wrap: col=COLS-1 SHALL advance to col 0, row+1.
REQ-025 Row wrap: row=ROWS-1 with col=COLS-1 SHALL advance to row 0, col 0.
REQ-026 In RUN, when rom_data==0 or cnt==MAX_LEN, the next edge SHALL set txt_we=0, busy=0, done=1, len=cnt, and return to IDLE; the terminator SHALL NOT be written.
REQ-027 When a character is written from ptr=2047, the copy SHALL terminate on the following RUN cycle as if a terminator had been read; ptr SHALL NOT wrap to 0.
REQ-028 done SHALL be high for exactly one cycle; txt_we SHALL be low in every cycle not directly following a write decision.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 start asserted in the same cycle that done=1 SHALL be accepted, because the block is then in IDLE.
REQ-031 len SHALL hold its value until the next completion.
REQ-032 A string whose first character is 0 SHALL produce no write, done one cycle after busy rises, and len=0.
REQ-033 txt_addr arithmetic SHALL use at least 12 bits with no truncation for row<=ROWS-1 and col<=COLS-1.

Reset
REQ-034 reset=1 SHALL force IDLE with busy=0, done=0, txt_we=0, txt_data=0, txt_addr=0, rom_addr=0 and len=0 at the next edge.
REQ-035 reset SHALL take priority over start and abort any RUN with no further writes.

Verification
REQ-036 ROM[15..24]="Ch1 Vdiv:",0; start with str_addr=15, row=2, col=5 -> 9 writes to txt_addr 165..173 with 'C','h','1',' ','V','d','i','v',':' on consecutive cycles; done one cycle after the last write; len=9.
REQ-037 str_addr=14 (ROM[14]=0) -> no txt_we, busy high for 1 cycle, done pulse, len=0.
REQ-038 row=29, col=78, 4-char string -> writes to addresses 2398, 2399, 0, 1.
REQ-039 A 100-char non-null region -> exactly 64 writes, len=64, done pulse; a second start during busy is ignored, with no extra writes.
REQ-040 Assert reset after the 3rd write of REQ-036 -> next edge txt_we=0, busy=0, done=0, len=0; no further writes; a new start then copies normally.
REQ-041 dst_col=100, dst_row=31 -> first write at txt_addr 0.
